// File: rtl/matrix_scan_driver_if.sv
// Signal bundle between the attack-round logic and the LED matrix scan driver.
// The master side supplies the frame and cursor; the slave side drives the matrix pins.
interface matrix_scan_driver_if #(
    parameter int DATA_WIDTH    = 35,
    parameter int COLUNE_SIZE   = 7,
    parameter int TOTAL_COLUNES = 5
);
    logic                     enable;
    logic [DATA_WIDTH-1:0]    matriz_data;
    logic [2:0]               x_coord_code;
    logic [2:0]               y_coord_code;
    logic                     cursor_en;
    logic [TOTAL_COLUNES-1:0] col_n;
    logic [COLUNE_SIZE-1:0]   row;
    logic                     frame_start;

    modport master (
        output enable, matriz_data, x_coord_code, y_coord_code, cursor_en,
        input  col_n, row, frame_start
    );

    modport slave (
        input  enable, matriz_data, x_coord_code, y_coord_code, cursor_en,
        output col_n, row, frame_start
    );
endinterface

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed 5x7 LED matrix driver with tear-free frame latching,
// inter-column blanking and a blinking cursor at the attack coordinate.
module matrix_scan_driver #(
    parameter int DATA_WIDTH    = 35,
    parameter int COLUNE_SIZE   = 7,
    parameter int TOTAL_COLUNES = 5,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter int BLINK_FRAMES  = 25
) (
    input  logic               clk,
    input  logic               reset,
    matrix_scan_driver_if.slave bus
);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int COL_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] SCAN_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(TOTAL_COLUNES - 1);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]         prescaler;
    logic [COL_W-1:0]         col_idx;
    logic [FC_W-1:0]          frame_cnt;
    logic                     blink_phase;
    logic [DATA_WIDTH-1:0]    frame_reg;
    logic                     tick;
    logic                     wrap;
    logic                     blanking;
    logic [COLUNE_SIZE-1:0]   disp_row;
    logic [TOTAL_COLUNES-1:0] col_drive;

    assign tick     = (prescaler == SCAN_LAST);
    assign wrap     = tick && (col_idx == COL_LAST);
    assign blanking = (prescaler < BLANK_END);

    // Invalid coordinate codes never match any (k+1, r+1) pair, so they simply produce no cursor.
    always_comb begin
        disp_row  = '0;
        col_drive = '1;
        for (int k = 0; k < TOTAL_COLUNES; k++) begin
            if (col_idx == COL_W'(k)) begin
                disp_row     = frame_reg[DATA_WIDTH-1-COLUNE_SIZE*k -: COLUNE_SIZE];
                col_drive[k] = 1'b0;
                if (bus.cursor_en && (bus.x_coord_code == 3'(k + 1))) begin
                    for (int r = 0; r < COLUNE_SIZE; r++) begin
                        if (bus.y_coord_code == 3'(r + 1)) begin
                            disp_row[r] = disp_row[r] ^ blink_phase;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler       <= '0;
            col_idx         <= '0;
            frame_cnt       <= '0;
            blink_phase     <= 1'b0;
            frame_reg       <= '0;
            bus.frame_start <= 1'b0;
            bus.col_n       <= '1;
            bus.row         <= '0;
        end else begin
            if (!bus.enable) begin
                // Track the input while off so the first frame shown after enable is current.
                prescaler       <= '0;
                col_idx         <= '0;
                frame_cnt       <= '0;
                blink_phase     <= 1'b0;
                frame_reg       <= bus.matriz_data;
                bus.frame_start <= 1'b0;
            end else begin
                bus.frame_start <= wrap;
                if (tick) begin
                    prescaler <= '0;
                    col_idx   <= (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
                if (wrap) begin
                    frame_reg <= bus.matriz_data;
                    if (frame_cnt == FC_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end
            end

            if (!bus.enable || blanking) begin
                bus.col_n <= '1;
                bus.row   <= '0;
            end else begin
                bus.col_n <= col_drive;
                bus.row   <= disp_row;
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2
// (one frame = 20 clocks; outputs sampled on the falling edge).
module tb_matrix_scan_driver;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    matrix_scan_driver_if #(.DATA_WIDTH(35), .COLUNE_SIZE(7), .TOTAL_COLUNES(5)) bif ();

    matrix_scan_driver #(
        .DATA_WIDTH(35), .COLUNE_SIZE(7), .TOTAL_COLUNES(5),
        .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic en, input logic [34:0] data,
                                  input logic ce, input logic [2:0] x, input logic [2:0] y);
        bif.enable       = en;
        bif.matriz_data  = data;
        bif.cursor_en    = ce;
        bif.x_coord_code = x;
        bif.y_coord_code = y;
    endtask

    task automatic check_output(input string tag, input logic [4:0] exp_col,
                                input logic [6:0] exp_row, input logic exp_fs);
        checks++;
        assert (bif.col_n === exp_col) else begin
            errors++;
            $error("[TB] FAIL %s col_n got %b want %b", tag, bif.col_n, exp_col);
        end
        checks++;
        assert (bif.row === exp_row) else begin
            errors++;
            $error("[TB] FAIL %s row got %h want %h", tag, bif.row, exp_row);
        end
        checks++;
        assert (bif.frame_start === exp_fs) else begin
            errors++;
            $error("[TB] FAIL %s frame_start got %b want %b", tag, bif.frame_start, exp_fs);
        end
    endtask

    // Walks ncyc clocks of one frame; cycle 1 is the blank slot of column 0.
    task automatic check_frame(input string tag, input logic [6:0] r0, input logic [6:0] r1,
                               input logic [6:0] r2, input logic [6:0] r3, input logic [6:0] r4,
                               input int ncyc, input logic chg, input logic [34:0] new_data);
        logic [6:0] rows [5];
        logic [4:0] pats [5];
        int slot;
        int ph;
        rows = '{r0, r1, r2, r3, r4};
        pats = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            slot = (i - 1) / 4;
            ph   = (i - 1) % 4;
            check_output($sformatf("%s_c%0d", tag, i),
                         (ph == 0) ? 5'b11111 : pats[slot],
                         (ph == 0) ? 7'h00 : rows[slot],
                         (i == 20));
            if (chg && i == 10) bif.matriz_data = new_data;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        apply_stimulus(1'b0, 35'h0, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        check_output("reset", 5'b11111, 7'h00, 1'b0);

        reset = 1'b0;
        apply_stimulus(1'b0, 35'h7FFFFFFFF, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        check_output("idle", 5'b11111, 7'h00, 1'b0);
        bif.enable = 1'b1;

        $display("[TB] all-ones frame scan");
        check_frame("ones_a", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 20, 1'b0, 35'h0);
        check_frame("ones_b", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 20, 1'b1, 35'h400000000);

        $display("[TB] frame latch only at boundary");
        check_frame("bit34", 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b1, 35'h000000001);
        check_frame("bit0",  7'h00, 7'h00, 7'h00, 7'h00, 7'h01, 20, 1'b1, 35'h000000000);

        $display("[TB] cursor blink at x=1 y=1");
        apply_stimulus(1'b1, 35'h0, 1'b1, 3'd1, 3'd1);
        check_frame("blink_e", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);
        check_frame("blink_f", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);
        check_frame("blink_g", 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);
        check_frame("blink_h", 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);

        $display("[TB] invalid cursor codes");
        apply_stimulus(1'b1, 35'h0, 1'b1, 3'd6, 3'd1);
        for (int f = 0; f < 4; f++)
            check_frame($sformatf("badx_%0d", f), 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);
        apply_stimulus(1'b1, 35'h0, 1'b1, 3'd1, 3'd0);
        for (int f = 0; f < 4; f++)
            check_frame($sformatf("bady_%0d", f), 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);

        $display("[TB] cursor at x=5 y=7");
        apply_stimulus(1'b1, 35'h0, 1'b1, 3'd5, 3'd7);
        check_frame("corner_q", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);
        check_frame("corner_r", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);
        check_frame("corner_s", 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 20, 1'b1, 35'h7FFFFFFFF);

        $display("[TB] enable drop during column 2");
        bif.cursor_en = 1'b0;
        check_frame("en_pre", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 10, 1'b0, 35'h0);
        apply_stimulus(1'b0, 35'h550000000, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output($sformatf("en_low_%0d", i), 5'b11111, 7'h00, 1'b0);
        end
        bif.enable = 1'b1;
        check_frame("en_post", 7'h55, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);

        $display("[TB] async reset during column 3");
        check_frame("rst_pre", 7'h55, 7'h00, 7'h00, 7'h00, 7'h00, 14, 1'b0, 35'h0);
        #2 reset = 1'b1;
        #1 check_output("rst_async", 5'b11111, 7'h00, 1'b0);
        @(negedge clk);
        check_output("rst_held", 5'b11111, 7'h00, 1'b0);
        reset = 1'b0;
        check_frame("rst_post", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);
        check_frame("rst_next", 7'h55, 7'h00, 7'h00, 7'h00, 7'h00, 20, 1'b0, 35'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
